// File: rtl/debug_cmd_engine.sv
// rtl/debug_cmd_engine.sv - debug-link command parser/executor with status-prefixed multi-byte responses
module debug_cmd_engine #(
    parameter int         LedWidth  = 4,
    parameter int         MsgLenMax = 8,
    parameter logic [7:0] Version   = 8'h02
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                inq_rok,
    input  logic [7:0]          inq_rd,
    output logic                inq_r,
    input  logic                outq_wok,
    output logic                outq_w,
    output logic [7:0]          outq_wd,
    output logic [LedWidth-1:0] led,
    output logic [7:0]          err_count
);

    localparam int LenW = $clog2(MsgLenMax + 1);
    localparam int IdxW = $clog2(MsgLenMax);
    localparam logic [7:0] MaxPayload = 8'(MsgLenMax - 1);

    localparam logic [7:0] OpNop     = 8'h00;
    localparam logic [7:0] OpLedSet  = 8'h80;
    localparam logic [7:0] OpLedGet  = 8'h81;
    localparam logic [7:0] OpEcho    = 8'h82;
    localparam logic [7:0] OpVersion = 8'h83;

    localparam logic [7:0] StatOk      = 8'h01;
    localparam logic [7:0] StatTooLong = 8'hFE;
    localparam logic [7:0] StatBadOp   = 8'hFF;

    typedef enum logic [2:0] {
        Fetch,
        Arg,
        Payload,
        Exec,
        Resp
    } state_t;

    state_t state, nextState;

    logic [7:0]          opcode;
    logic [7:0]          argByte;
    logic [7:0]          echoLeft;
    logic [LenW-1:0]     respLen;
    logic [LenW-1:0]     idx;
    logic [LenW-1:0]     payIdx;
    logic [7:0]          respBuf [MsgLenMax];
    logic [LedWidth-1:0] ledReg;
    logic [7:0]          errCount;
    logic                inRead;
    logic                lastByte;

    assign inRead   = (state == Fetch) || (state == Arg) || (state == Payload);
    assign lastByte = (idx == respLen - 1'b1);

    // Strobes are forced low while reset is held so nothing is consumed or emitted.
    assign inq_r     = inRead && !rst;
    assign outq_w    = (state == Resp) && !rst;
    assign outq_wd   = (state == Resp && !rst) ? respBuf[IdxW'(idx)] : 8'h00;
    assign led       = ledReg;
    assign err_count = errCount;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= Fetch;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            Fetch: begin
                if (inq_rok) begin
                    if (inq_rd == OpNop) begin
                        nextState = Fetch;
                    end else if (inq_rd == OpLedSet || inq_rd == OpEcho) begin
                        nextState = Arg;
                    end else begin
                        nextState = Exec;
                    end
                end
            end
            Arg: begin
                if (inq_rok) begin
                    nextState = (opcode == OpEcho && inq_rd != 8'd0) ? Payload : Exec;
                end
            end
            Payload: begin
                if (inq_rok && echoLeft == 8'd1) begin
                    nextState = Exec;
                end
            end
            Exec: begin
                nextState = Resp;
            end
            Resp: begin
                if (outq_wok && lastByte) begin
                    nextState = Fetch;
                end
            end
            default: begin
                nextState = Fetch;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            opcode   <= 8'h00;
            argByte  <= 8'h00;
            echoLeft <= 8'h00;
            respLen  <= '0;
            idx      <= '0;
            payIdx   <= '0;
            ledReg   <= '0;
            errCount <= 8'h00;
            for (int i = 0; i < MsgLenMax; i++) begin
                respBuf[i] <= 8'h00;
            end
        end else begin
            case (state)
                Fetch: begin
                    if (inq_rok) begin
                        opcode <= inq_rd;
                    end
                end
                Arg: begin
                    if (inq_rok) begin
                        argByte  <= inq_rd;
                        echoLeft <= inq_rd;
                        payIdx   <= LenW'(1);
                    end
                end
                Payload: begin
                    // Oversized echoes are still drained byte-for-byte to keep the stream framed.
                    if (inq_rok) begin
                        echoLeft <= echoLeft - 8'd1;
                        if (argByte <= MaxPayload) begin
                            respBuf[IdxW'(payIdx)] <= inq_rd;
                            payIdx <= payIdx + 1'b1;
                        end
                    end
                end
                Exec: begin
                    idx        <= '0;
                    respLen    <= LenW'(1);
                    respBuf[0] <= StatOk;
                    case (opcode)
                        OpLedSet: begin
                            ledReg <= argByte[LedWidth-1:0];
                        end
                        OpLedGet: begin
                            respBuf[1] <= 8'(ledReg);
                            respLen    <= LenW'(2);
                        end
                        OpEcho: begin
                            if (argByte > MaxPayload) begin
                                respBuf[0] <= StatTooLong;
                                if (errCount != 8'hFF) begin
                                    errCount <= errCount + 8'd1;
                                end
                            end else begin
                                respLen <= LenW'(argByte) + 1'b1;
                            end
                        end
                        OpVersion: begin
                            respBuf[1] <= Version;
                            respLen    <= LenW'(2);
                        end
                        default: begin
                            respBuf[0] <= StatBadOp;
                            if (errCount != 8'hFF) begin
                                errCount <= errCount + 8'd1;
                            end
                        end
                    endcase
                end
                Resp: begin
                    if (outq_wok && !lastByte) begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_debug_cmd_engine.sv
// tb/tb_debug_cmd_engine.sv - directed bench for debug_cmd_engine with FIFO models on both sides
module tb_debug_cmd_engine;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       inq_rok = 1'b0;
    logic [7:0] inq_rd = 8'h00;
    logic       outq_wok = 1'b1;
    logic       inq_r;
    logic       outq_w;
    logic [7:0] outq_wd;
    logic [3:0] led;
    logic [7:0] err_count;

    int testsRun = 0;
    int testsFailed = 0;
    int edgeCnt = 0;
    int lastPopEdge = 0;
    logic [7:0] inQ[$];
    logic [7:0] outQ[$];
    int capEdge[$];
    bit popPend = 1'b0;
    bit capPend = 1'b0;
    logic [7:0] capByte = 8'h00;

    debug_cmd_engine #(.LedWidth(4), .MsgLenMax(8), .Version(8'h02)) dut (
        .clk       (clk),
        .rst       (rst),
        .inq_rok   (inq_rok),
        .inq_rd    (inq_rd),
        .inq_r     (inq_r),
        .outq_wok  (outq_wok),
        .outq_w    (outq_w),
        .outq_wd   (outq_wd),
        .led       (led),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edgeCnt++;

    // Handshakes are sampled mid-cycle and retired at the following negedge.
    always @(negedge clk) begin
        if (popPend) begin
            lastPopEdge = edgeCnt;
            void'(inQ.pop_front());
        end
        if (capPend) begin
            outQ.push_back(capByte);
            capEdge.push_back(edgeCnt);
        end
        inq_rok = (inQ.size() > 0);
        inq_rd  = inq_rok ? inQ[0] : 8'h00;
        popPend = !rst && inq_r && inq_rok;
        capPend = !rst && outq_w && outq_wok;
        capByte = outq_wd;
    end

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [7:0] b);
        inQ.push_back(b);
        inq_rok = 1'b1;
        inq_rd  = inQ[0];
    endtask

    task automatic waitCaps(input string tag, input int n, input int budget);
        int k = 0;
        while (outQ.size() < n && k < budget) begin
            tick();
            k++;
        end
        checkVal({tag, " timeout"}, 32'(outQ.size() >= n), 32'd1);
    endtask

    task automatic expectByte(input string tag, input logic [7:0] exp);
        logic [7:0] b;
        if (outQ.size() == 0) begin
            checkVal(tag, 32'hFFFF_FFFF, {24'h0, exp});
        end else begin
            b = outQ.pop_front();
            void'(capEdge.pop_front());
            checkVal(tag, {24'h0, b}, {24'h0, exp});
        end
    endtask

    task automatic expectIdle(input string tag);
        tick(6);
        checkVal(tag, outQ.size(), 0);
    endtask

    initial begin
        int ffCnt;
        logic [7:0] b;

        rst = 1'b1;
        tick(3);
        checkVal("rst inq_r", inq_r, 0);
        checkVal("rst outq_w", outq_w, 0);
        checkVal("rst outq_wd", outq_wd, 0);
        checkVal("rst led", led, 0);
        checkVal("rst err_count", err_count, 0);
        rst = 1'b0;
        tick(2);
        checkVal("idle inq_r", inq_r, 1);
        checkVal("idle outq_w", outq_w, 0);

        push(8'h80); push(8'h05);
        waitCaps("ledset", 1, 20);
        expectByte("ledset status", 8'h01);
        checkVal("ledset led", led, 4'h5);
        push(8'h81);
        waitCaps("ledget", 2, 20);
        expectByte("ledget status", 8'h01);
        expectByte("ledget value", 8'h05);
        expectIdle("ledget extra");

        push(8'h82); push(8'h03); push(8'hAA); push(8'hBB); push(8'hCC);
        waitCaps("echo3", 4, 40);
        if (capEdge.size() > 0) checkVal("echo latency", capEdge[0] - lastPopEdge, 2);
        else checkVal("echo latency", 32'hFFFF_FFFF, 2);
        expectByte("echo3 status", 8'h01);
        expectByte("echo3 b0", 8'hAA);
        expectByte("echo3 b1", 8'hBB);
        expectByte("echo3 b2", 8'hCC);
        expectIdle("echo3 extra");

        push(8'h82); push(8'h09);
        for (int i = 1; i <= 9; i++) push(8'(i));
        waitCaps("echo9", 1, 60);
        expectByte("echo9 status", 8'hFE);
        checkVal("echo9 err_count", err_count, 1);
        checkVal("echo9 drained", inQ.size(), 0);
        push(8'h83);
        waitCaps("version", 2, 20);
        expectByte("version status", 8'h01);
        expectByte("version value", 8'h02);
        expectIdle("version extra");

        for (int i = 0; i < 300; i++) push(8'h3C);
        waitCaps("badop", 300, 3000);
        ffCnt = 0;
        while (outQ.size() > 0) begin
            b = outQ.pop_front();
            void'(capEdge.pop_front());
            if (b == 8'hFF) ffCnt++;
        end
        checkVal("badop FF count", ffCnt, 300);
        checkVal("badop err sat", err_count, 8'hFF);
        expectIdle("badop extra");

        outq_wok = 1'b0;
        push(8'h81);
        for (int k = 0; k < 20 && !outq_w; k++) tick();
        checkVal("stall reached resp", outq_w, 1);
        outq_wok = 1'b1;
        tick();
        outq_wok = 1'b0;
        push(8'h00);
        for (int k = 0; k < 10; k++) begin
            tick();
            checkVal("stall outq_w", outq_w, 1);
            checkVal("stall outq_wd", outq_wd, 8'h05);
            checkVal("stall inq_r", inq_r, 0);
        end
        checkVal("stall one byte", outQ.size(), 1);
        outq_wok = 1'b1;
        waitCaps("stall", 2, 20);
        expectByte("stall status", 8'h01);
        expectByte("stall value", 8'h05);
        expectIdle("stall extra");
        checkVal("stall nop drained", inQ.size(), 0);

        push(8'h82); push(8'h04); push(8'h11); push(8'h22);
        tick(8);
        checkVal("payload waiting inq_r", inq_r, 1);
        rst = 1'b1;
        tick();
        checkVal("midrst inq_r", inq_r, 0);
        checkVal("midrst outq_w", outq_w, 0);
        checkVal("midrst outq_wd", outq_wd, 0);
        checkVal("midrst led", led, 0);
        checkVal("midrst err_count", err_count, 0);
        rst = 1'b0;
        tick();
        push(8'h81);
        waitCaps("postrst", 2, 20);
        expectByte("postrst status", 8'h01);
        expectByte("postrst value", 8'h00);
        expectIdle("postrst extra");

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
